// File: rtl/router_pkg.sv
// Shared state encoding and channel helpers for the N-channel router control FSM.
package router_pkg;

  typedef enum logic [3:0] {
    DECODE_ADDRESS     = 4'd0,
    LOAD_FIRST_DATA    = 4'd1,
    LOAD_DATA          = 4'd2,
    WAIT_TILL_EMPTY    = 4'd3,
    FIFO_FULL_STATE    = 4'd4,
    LOAD_AFTER_FULL    = 4'd5,
    LOAD_PARITY        = 4'd6,
    CHECK_PARITY_ERROR = 4'd7,
    DROP_PACKET        = 4'd8
  } state_e;

  localparam int MAX_CH = 16;

  function automatic logic addr_legal(input int unsigned addr, input int unsigned num_ch);
    return addr < num_ch;
  endfunction

  // Illegal addresses select nothing, so callers can AND with per-channel flags safely.
  function automatic logic [MAX_CH-1:0] onehot(input int unsigned addr, input int unsigned num_ch);
    if (addr < num_ch && addr < MAX_CH) return MAX_CH'(1) << addr;
    return '0;
  endfunction

endpackage

// File: rtl/router_wait_timer.sv
// Bounded WAIT_TILL_EMPTY timer: counts cycles spent waiting and raises a
// registered one-cycle timeout_err when the wait expires without being released.
module router_wait_timer #(
  parameter int WAIT_TO = 32
) (
  input  logic clock,
  input  logic resetn,
  input  logic in_wait,
  input  logic hold,
  output logic expire,
  output logic timeout_err
);

  // A zero-width counter is not legal, so the disabled case keeps one bit.
  localparam int CNT_W = (WAIT_TO > 0) ? $clog2(WAIT_TO + 1) : 1;

  logic [CNT_W-1:0] wait_cnt;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      wait_cnt    <= in_wait ? wait_cnt + 1'b1 : '0;
      timeout_err <= in_wait && expire && !hold;
    end
  end

  generate
    if (WAIT_TO == 0) begin : g_no_timeout
      assign expire = 1'b0;
    end else begin : g_timeout
      assign expire = (wait_cnt == CNT_W'(WAIT_TO - 1));
    end
  endgenerate

endmodule

// File: rtl/router_fsm_nch.sv
// N-channel router control FSM with illegal-address drop and bounded wait.
// Define ROUTER_FSM_STATS_EN to add saturating drop_count/timeout_count outputs.
module router_fsm_nch
  import router_pkg::*;
#(
  parameter int NUM_CH  = 3,
  parameter int ADDR_W  = 2,
  parameter int WAIT_TO = 32
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              pkt_valid,
  input  logic [ADDR_W-1:0] data_in,
  input  logic              fifo_full,
  input  logic [NUM_CH-1:0] fifo_empty,
  input  logic [NUM_CH-1:0] soft_reset,
  input  logic              parity_done,
  input  logic              low_pkt_valid,
  output logic              detect_add,
  output logic              lfd_state,
  output logic              ld_state,
  output logic              laf_state,
  output logic              full_state,
  output logic              write_enb_reg,
  output logic              rst_int_reg,
  output logic              busy,
  output logic              drop_state,
  output logic [ADDR_W-1:0] addr_q,
  output logic [NUM_CH-1:0] write_sel,
  output logic              timeout_err
`ifdef ROUTER_FSM_STATS_EN
  ,
  output logic [15:0]       drop_count,
  output logic [15:0]       timeout_count
`endif
);

  state_e            state, next_state;
  logic [NUM_CH-1:0] hdr_sel, addr_sel;
  logic              hdr_legal, hdr_empty, addr_empty, sr_hit, in_wait, expire;

  assign hdr_sel    = NUM_CH'(onehot(32'(data_in), NUM_CH));
  assign addr_sel   = NUM_CH'(onehot(32'(addr_q), NUM_CH));
  assign hdr_legal  = addr_legal(32'(data_in), NUM_CH);
  assign hdr_empty  = |(fifo_empty & hdr_sel);
  assign addr_empty = |(fifo_empty & addr_sel);
  // addr_sel is zero for an illegal addr_q, so a dropped packet ignores soft reset.
  assign sr_hit     = |(soft_reset & addr_sel);
  assign in_wait    = (state == WAIT_TILL_EMPTY);

  router_wait_timer #(.WAIT_TO(WAIT_TO)) u_wait_timer (
    .clock      (clock),
    .resetn     (resetn),
    .in_wait    (in_wait),
    .hold       (addr_empty | sr_hit),
    .expire     (expire),
    .timeout_err(timeout_err)
  );

  always_comb begin
    next_state = state;
    case (state)
      DECODE_ADDRESS:
        if (pkt_valid) begin
          if (!hdr_legal)     next_state = DROP_PACKET;
          else if (hdr_empty) next_state = LOAD_FIRST_DATA;
          else                next_state = WAIT_TILL_EMPTY;
        end
      WAIT_TILL_EMPTY:
        if (addr_empty)  next_state = LOAD_FIRST_DATA;
        else if (expire) next_state = DROP_PACKET;
      LOAD_FIRST_DATA: next_state = LOAD_DATA;
      LOAD_DATA:
        if (fifo_full)       next_state = FIFO_FULL_STATE;
        else if (!pkt_valid) next_state = LOAD_PARITY;
      FIFO_FULL_STATE:
        if (!fifo_full) next_state = LOAD_AFTER_FULL;
      LOAD_AFTER_FULL:
        if (parity_done)        next_state = DECODE_ADDRESS;
        else if (low_pkt_valid) next_state = LOAD_PARITY;
        else                    next_state = LOAD_DATA;
      LOAD_PARITY:        next_state = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: next_state = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      DROP_PACKET:
        if (!pkt_valid) next_state = DECODE_ADDRESS;
      default:            next_state = DECODE_ADDRESS;
    endcase
    if (sr_hit) next_state = DECODE_ADDRESS;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= DECODE_ADDRESS;
    else         state <= next_state;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)                       addr_q <= '0;
    else if (detect_add && pkt_valid)  addr_q <= data_in;
  end

  assign detect_add    = (state == DECODE_ADDRESS);
  assign lfd_state     = (state == LOAD_FIRST_DATA);
  assign ld_state      = (state == LOAD_DATA);
  assign laf_state     = (state == LOAD_AFTER_FULL);
  assign full_state    = (state == FIFO_FULL_STATE);
  assign rst_int_reg   = (state == CHECK_PARITY_ERROR);
  assign drop_state    = (state == DROP_PACKET);
  assign write_enb_reg = ld_state | laf_state | (state == LOAD_PARITY);
  assign busy          = !(detect_add | ld_state | drop_state);
  assign write_sel     = (write_enb_reg | lfd_state) ? addr_sel : '0;

`ifdef ROUTER_FSM_STATS_EN
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      drop_count    <= '0;
      timeout_count <= '0;
    end else begin
      if (next_state == DROP_PACKET && state != DROP_PACKET && drop_count != 16'hFFFF)
        drop_count <= drop_count + 16'd1;
      if (timeout_err && timeout_count != 16'hFFFF)
        timeout_count <= timeout_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_router_fsm_nch.sv
// Self-checking bench for router_fsm_nch: directed scenarios plus random traffic
// compared against a state-name reference model of the packet protocol.
module tb_router_fsm_nch;
  localparam int NUM_CH = 3, ADDR_W = 2, WAIT_TO = 32;

  logic clock = 1'b0, resetn = 1'b1;
  logic pkt_valid, fifo_full, parity_done, low_pkt_valid;
  logic [ADDR_W-1:0] data_in;
  logic [NUM_CH-1:0] fifo_empty, soft_reset;
  logic detect_add, lfd_state, ld_state, laf_state, full_state;
  logic write_enb_reg, rst_int_reg, busy, drop_state, timeout_err;
  logic [ADDR_W-1:0] addr_q;
  logic [NUM_CH-1:0] write_sel;
`ifdef ROUTER_FSM_STATS_EN
  logic [15:0] drop_count, timeout_count;
`endif

  always #5 clock = ~clock;

  router_fsm_nch #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .WAIT_TO(WAIT_TO)) dut (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .soft_reset(soft_reset),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
    .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state), .write_enb_reg(write_enb_reg),
    .rst_int_reg(rst_int_reg), .busy(busy), .drop_state(drop_state),
    .addr_q(addr_q), .write_sel(write_sel), .timeout_err(timeout_err)
`ifdef ROUTER_FSM_STATS_EN
    , .drop_count(drop_count), .timeout_count(timeout_count)
`endif
  );

  typedef enum {M_DEC, M_LFD, M_LD, M_WAIT, M_FFS, M_LAF, M_LP, M_CPE, M_DROP} mst_t;
  mst_t m_state;
  int   m_addr, m_wait, m_drops, m_touts;
  bit   m_to;
  int   errors = 0, checks = 0;

  function automatic logic [14:0] obs();
    return {detect_add, lfd_state, ld_state, laf_state, full_state, write_enb_reg,
            rst_int_reg, busy, drop_state, timeout_err, addr_q, write_sel};
  endfunction

  // Flag order: detect, lfd, ld, laf, full, write_enb, rst_int, busy, drop.
  function automatic logic [14:0] expv();
    logic [8:0] f;
    logic [2:0] ws;
    case (m_state)
      M_DEC:   f = 9'b100000000;
      M_LFD:   f = 9'b010000010;
      M_LD:    f = 9'b001001000;
      M_WAIT:  f = 9'b000000010;
      M_FFS:   f = 9'b000010010;
      M_LAF:   f = 9'b000101010;
      M_LP:    f = 9'b000001010;
      M_CPE:   f = 9'b000000110;
      default: f = 9'b000000001;
    endcase
    ws = (f[7] || f[3]) ? 3'(1 << m_addr) : 3'b000;
    return {f, m_to, 2'(m_addr), ws};
  endfunction

  task automatic model_reset();
    m_state = M_DEC; m_addr = 0; m_wait = 0; m_to = 0; m_drops = 0; m_touts = 0;
  endtask

  task automatic idle_inputs();
    pkt_valid = 0; data_in = '0; fifo_full = 0; fifo_empty = '1;
    soft_reset = '0; parity_done = 0; low_pkt_valid = 0;
  endtask

  // Advance one clock and move the model by the protocol rules.
  task automatic tick();
    mst_t nx;
    bit to, sr;
    sr = (m_addr < NUM_CH) && soft_reset[m_addr];
    nx = m_state; to = 0;
    case (m_state)
      M_DEC: if (pkt_valid) begin
        if (int'(data_in) >= NUM_CH) nx = M_DROP;
        else if (fifo_empty[data_in]) nx = M_LFD;
        else nx = M_WAIT;
      end
      M_WAIT: if (fifo_empty[m_addr]) nx = M_LFD;
              else if (WAIT_TO != 0 && m_wait == WAIT_TO - 1) begin nx = M_DROP; to = 1; end
      M_LFD:  nx = M_LD;
      M_LD:   if (fifo_full) nx = M_FFS; else if (!pkt_valid) nx = M_LP;
      M_FFS:  if (!fifo_full) nx = M_LAF;
      M_LAF:  nx = parity_done ? M_DEC : (low_pkt_valid ? M_LP : M_LD);
      M_LP:   nx = M_CPE;
      M_CPE:  nx = fifo_full ? M_FFS : M_DEC;
      default: if (!pkt_valid) nx = M_DEC;
    endcase
    if (sr) begin nx = M_DEC; to = 0; end
    if (m_to) m_touts++;
    if (nx == M_DROP && m_state != M_DROP) m_drops++;
    m_wait = (m_state == M_WAIT && nx == M_WAIT) ? m_wait + 1 : 0;
    if (m_state == M_DEC && pkt_valid) m_addr = int'(data_in);
    @(posedge clock); #1;
    m_state = nx; m_to = to;
  endtask

  task automatic test_reset();
    idle_inputs();
    resetn = 0; #3;
    model_reset();
    checks++; if (obs() !== expv()) begin errors++; $display("FAIL reset_outputs got=%h exp=%h", obs(), expv()); end
    checks++; if (detect_add !== 1'b1 || busy !== 1'b0 || write_sel !== 3'b000) begin
      errors++; $display("FAIL reset_decode got detect=%b busy=%b sel=%b exp 1 0 000", detect_add, busy, write_sel); end
    @(posedge clock); #1; resetn = 1;
    tick();
    checks++; if (obs() !== expv()) begin errors++; $display("FAIL reset_idle got=%h exp=%h", obs(), expv()); end
  endtask

  task automatic test_packet();
    bit pv[9] = '{1, 1, 1, 1, 1, 0, 0, 0, 0};
    int ld_cnt = 0;
    data_in = 2'd1;
    for (int c = 0; c < 9; c++) begin
      pkt_valid = pv[c];
      checks++; if (obs() !== expv()) begin errors++; $display("FAIL packet c=%0d got=%h exp=%h", c, obs(), expv()); end
      if (write_enb_reg || lfd_state) begin
        checks++; if (write_sel !== 3'b010) begin errors++; $display("FAIL packet_sel c=%0d got=%b exp=010", c, write_sel); end
      end
      if (ld_state) begin
        ld_cnt++;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL packet_busy c=%0d got=%b exp=0", c, busy); end
      end
      tick();
    end
    checks++; if (ld_cnt != 4) begin errors++; $display("FAIL packet_ld_cycles got=%0d exp=4", ld_cnt); end
    checks++; if (detect_add !== 1'b1) begin errors++; $display("FAIL packet_end got=%b exp=1", detect_add); end
  endtask

  task automatic test_drop();
    int n = $urandom_range(2, 6);
    data_in = 2'd3;
    for (int c = 0; c <= n; c++) begin
      pkt_valid = (c < n);
      checks++; if (obs() !== expv()) begin errors++; $display("FAIL drop c=%0d got=%h exp=%h", c, obs(), expv()); end
      checks++; if (drop_state !== (c >= 1) || write_sel !== 3'b000) begin
        errors++; $display("FAIL drop_state c=%0d got drop=%b sel=%b exp drop=%b sel=000", c, drop_state, write_sel, c >= 1); end
      tick();
    end
    checks++; if (detect_add !== 1'b1) begin errors++; $display("FAIL drop_return got=%b exp=1", detect_add); end
`ifdef ROUTER_FSM_STATS_EN
    checks++; if (drop_count !== 16'd1) begin errors++; $display("FAIL drop_count got=%0d exp=1", drop_count); end
`endif
  endtask

  task automatic test_timeout();
    int waits = 0, pulses = 0;
    data_in = 2'd2; fifo_empty = 3'b011; pkt_valid = 1;
    for (int c = 0; c < 36; c++) begin
      checks++; if (obs() !== expv()) begin errors++; $display("FAIL timeout c=%0d got=%h exp=%h", c, obs(), expv()); end
      if (busy && !lfd_state && !full_state && !write_enb_reg && !rst_int_reg) waits++;
      if (timeout_err) begin
        pulses++;
        checks++; if (drop_state !== 1'b1 || c != 33) begin
          errors++; $display("FAIL timeout_pulse c=%0d drop=%b exp c=33 drop=1", c, drop_state); end
      end
      tick();
    end
    checks++; if (waits != 32) begin errors++; $display("FAIL timeout_wait_cycles got=%0d exp=32", waits); end
    checks++; if (pulses != 1) begin errors++; $display("FAIL timeout_pulses got=%0d exp=1", pulses); end
    pkt_valid = 0; fifo_empty = '1;
    tick();
    checks++; if (detect_add !== 1'b1) begin errors++; $display("FAIL timeout_exit got=%b exp=1", detect_add); end
`ifdef ROUTER_FSM_STATS_EN
    checks++; if (timeout_count !== 16'd1) begin errors++; $display("FAIL timeout_count got=%0d exp=1", timeout_count); end
`endif
  endtask

  task automatic test_race();
    int guard = 0;
    data_in = 2'd0; fifo_empty = 3'b110; pkt_valid = 1;
    while (!(m_state == M_WAIT && m_wait == WAIT_TO - 1) && guard < 40) begin
      checks++; if (obs() !== expv()) begin errors++; $display("FAIL race_wait g=%0d got=%h exp=%h", guard, obs(), expv()); end
      tick(); guard++;
    end
    checks++; if (guard != 32) begin errors++; $display("FAIL race_reach got=%0d exp=32", guard); end
    fifo_empty = 3'b111;
    tick();
    checks++; if (lfd_state !== 1'b1 || timeout_err !== 1'b0 || drop_state !== 1'b0) begin
      errors++; $display("FAIL race_release got lfd=%b to=%b drop=%b exp 1 0 0", lfd_state, timeout_err, drop_state); end
    pkt_valid = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++; if (obs() !== expv()) begin errors++; $display("FAIL race_tail c=%0d got=%h exp=%h", c, obs(), expv()); end
    end
  endtask

  task automatic test_full();
    bit pv[9]  = '{1, 1, 1, 0, 0, 0, 0, 0, 0};
    bit ff[9]  = '{0, 0, 1, 1, 1, 0, 0, 0, 0};
    bit lpv[9] = '{0, 0, 0, 0, 0, 0, 1, 0, 0};
    int full_cnt = 0, laf_cnt = 0;
    data_in = 2'd1;
    for (int c = 0; c < 9; c++) begin
      pkt_valid = pv[c]; fifo_full = ff[c]; low_pkt_valid = lpv[c];
      checks++; if (obs() !== expv()) begin errors++; $display("FAIL full c=%0d got=%h exp=%h", c, obs(), expv()); end
      full_cnt += int'(full_state); laf_cnt += int'(laf_state);
      tick();
    end
    low_pkt_valid = 0;
    checks++; if (full_cnt != 3 || laf_cnt != 1) begin
      errors++; $display("FAIL full_cycles got ffs=%0d laf=%0d exp 3 1", full_cnt, laf_cnt); end
    checks++; if (detect_add !== 1'b1) begin errors++; $display("FAIL full_end got=%b exp=1", detect_add); end
  endtask

  task automatic test_soft_reset();
    data_in = 2'd1; pkt_valid = 1;
    tick(); tick();
    checks++; if (ld_state !== 1'b1) begin errors++; $display("FAIL sreset_pre got=%b exp=1", ld_state); end
    soft_reset = 3'b010;
    tick();
    soft_reset = '0; pkt_valid = 0;
    checks++; if (detect_add !== 1'b1 || ld_state !== 1'b0) begin
      errors++; $display("FAIL sreset_decode got detect=%b ld=%b exp 1 0", detect_add, ld_state); end
    checks++; if (obs() !== expv()) begin errors++; $display("FAIL sreset_model got=%h exp=%h", obs(), expv()); end
  endtask

  task automatic test_async_reset();
    data_in = 2'd2; pkt_valid = 1;
    tick(); tick();
    fifo_full = 1; tick();
    fifo_full = 0; tick();
    checks++; if (laf_state !== 1'b1) begin errors++; $display("FAIL areset_pre got=%b exp=1", laf_state); end
    #2 resetn = 0; #1;
    model_reset();
    checks++; if (detect_add !== 1'b1 || addr_q !== 2'd0 || laf_state !== 1'b0) begin
      errors++; $display("FAIL areset_async got detect=%b addr=%0d laf=%b exp 1 0 0", detect_add, addr_q, laf_state); end
    idle_inputs();
    @(posedge clock); #1; resetn = 1;
    checks++; if (obs() !== expv()) begin errors++; $display("FAIL areset_model got=%h exp=%h", obs(), expv()); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      pkt_valid     = ($urandom_range(0, 9) < 8);
      data_in       = 2'($urandom_range(0, 3));
      fifo_empty    = 3'($urandom_range(0, 7));
      fifo_full     = ($urandom_range(0, 3) == 0);
      soft_reset    = ($urandom_range(0, 31) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      parity_done   = ($urandom_range(0, 4) == 0);
      low_pkt_valid = ($urandom_range(0, 4) == 0);
      checks++; if (obs() !== expv()) begin errors++; $display("FAIL random c=%0d got=%h exp=%h", c, obs(), expv()); end
      tick();
    end
`ifdef ROUTER_FSM_STATS_EN
    checks++; if (drop_count !== 16'(m_drops) || timeout_count !== 16'(m_touts)) begin
      errors++; $display("FAIL random_stats got drops=%0d touts=%0d exp %0d %0d", drop_count, timeout_count, m_drops, m_touts); end
`endif
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_packet();
    test_drop();
    test_timeout();
    test_race();
    test_full();
    test_soft_reset();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/router_fsm_nch.md
Name: router_fsm_nch

Overview:
Parametrised successor to the 1x3 router control FSM. Sequences header decode, first-data load, payload load, FIFO-full stall, parity load and parity check for NUM_CH output channels. Adds three behaviours: illegal-address packet drop, a bounded wait-till-empty timeout, and one-hot per-channel write select. Sits between the input register block and the NUM_CH output FIFOs, in place of the fixed 3-channel FSM.

Parameters:
- NUM_CH, 3, number of output channels/FIFOs; range 2..16.
- ADDR_W, 2, header address field width; must satisfy 2**ADDR_W >= NUM_CH.
- WAIT_TO, 32, maximum cycles spent in WAIT_TILL_EMPTY; 0 disables the timeout.
- CNT_W, $clog2(WAIT_TO+1), wait counter width (derived, not overridden).

Ports:
- clock  in  1  system clock, rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- pkt_valid  in  1  packet byte valid from source.
- data_in  in  ADDR_W  header address bits, meaningful in DECODE_ADDRESS.
- fifo_full  in  1  full flag of the currently selected FIFO.
- fifo_empty  in  NUM_CH  per-channel empty flags.
- soft_reset  in  NUM_CH  per-channel soft reset (read-side timeout).
- parity_done  in  1  parity byte written (from register block).
- low_pkt_valid  in  1  pkt_valid fell while in FIFO_FULL_STATE.
- detect_add, lfd_state, ld_state, laf_state, full_state  out  1  state decodes.
- write_enb_reg  out  1  register block may write a byte.
- rst_int_reg  out  1  high in CHECK_PARITY_ERROR.
- busy  out  1  stall source.
- drop_state  out  1  high in DROP_PACKET.
- addr_q  out  ADDR_W  latched destination address.
- write_sel  out  NUM_CH  one-hot FIFO write select.
- timeout_err  out  1  one-cycle pulse when the wait timeout fires.

Behaviour:
- Reset (async, resetn=0): state=DECODE_ADDRESS, addr_q=0, wait_cnt=0, timeout_err=0. Outputs then: detect_add=1; all others 0.
- addr_q loads data_in when detect_add && pkt_valid.
- Legal address: data_in < NUM_CH.
- DECODE_ADDRESS, when pkt_valid is high:
  - illegal address -> DROP_PACKET;
  - legal and fifo_empty[data_in] -> LOAD_FIRST_DATA;
  - legal and not empty -> WAIT_TILL_EMPTY.
  - Otherwise stay.
- WAIT_TILL_EMPTY:
  - wait_cnt clears on entry and increments each cycle.
  - fifo_empty[addr_q] -> LOAD_FIRST_DATA. This wins over the timeout in the same cycle.
  - Else, if WAIT_TO!=0 and wait_cnt==WAIT_TO-1 -> DROP_PACKET, with timeout_err pulsed one cycle (registered, coincident with the DROP_PACKET entry edge).
- LOAD_FIRST_DATA -> LOAD_DATA unconditionally.
- LOAD_DATA:
  - fifo_full -> FIFO_FULL_STATE;
  - else ~pkt_valid -> LOAD_PARITY;
  - else stay.
- FIFO_FULL_STATE: ~fifo_full -> LOAD_AFTER_FULL.
- LOAD_AFTER_FULL, in priority order:
  - parity_done -> DECODE_ADDRESS;
  - low_pkt_valid -> LOAD_PARITY;
  - else -> LOAD_DATA.
- LOAD_PARITY -> CHECK_PARITY_ERROR.
- CHECK_PARITY_ERROR: fifo_full -> FIFO_FULL_STATE, else -> DECODE_ADDRESS.
- DROP_PACKET:
  - Bytes are consumed and never written.
  - ~pkt_valid (parity byte cycle) -> DECODE_ADDRESS.
- Soft reset: soft_reset[addr_q] && addr_q<NUM_CH forces state to DECODE_ADDRESS on the next edge, overriding next_state. It has no effect while in DROP_PACKET if addr_q is illegal.
- busy = 0 in DECODE_ADDRESS, LOAD_DATA and DROP_PACKET; 1 elsewhere.
- write_enb_reg = LOAD_DATA | LOAD_AFTER_FULL | LOAD_PARITY.
- write_sel = one-hot(addr_q) when write_enb_reg | lfd_state; else all zeros. write_sel is never non-zero in DROP_PACKET.
- Unused state encodings -> DECODE_ADDRESS.
- All state outputs are combinational decodes of the state register; the only registered outputs are addr_q and timeout_err.

Optional Feature:
ROUTER_FSM_STATS_EN.
- Defined: adds outputs drop_count[15:0] and timeout_count[15:0].
  - drop_count increments on each entry to DROP_PACKET.
  - timeout_count increments on each timeout_err pulse.
  - Both saturate at 16'hFFFF and clear on resetn=0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package router_pkg:
  - state enum/localparams, including DROP_PACKET as a 4-bit encoding;
  - a function onehot(addr, NUM_CH);
  - a function addr_legal(addr, NUM_CH).
- Sub-module router_wait_timer: wait_cnt, terminal detect and the timeout_err register, parameterised by WAIT_TO.

Test Plan:
1. NUM_CH=3, empty FIFO 1, header data_in=1, 4 payload bytes, parity -> state sequence DECODE, LFD, LD x4, LP, CPE, DECODE; write_sel=3'b010 while writing; busy low in LD.
2. NUM_CH=3, header data_in=3 -> DROP_PACKET for the packet length; write_sel=0 throughout; return to DECODE the cycle after pkt_valid falls; drop_count=1 with ROUTER_FSM_STATS_EN.
3. WAIT_TO=32, fifo_empty[2]=0 held -> exactly 32 WAIT cycles, then DROP_PACKET; timeout_err high one cycle.
4. fifo_empty[0] rises on the same cycle wait_cnt==WAIT_TO-1 -> LOAD_FIRST_DATA; no timeout_err.
5. fifo_full asserted in LD for 3 cycles, pkt_valid falls during full -> FFS x3, LAF, LP (low_pkt_valid=1), CPE.
6. soft_reset[1] during LD on channel 1 -> DECODE next edge. Separately, resetn pulled low mid-LAF -> immediate async DECODE, addr_q=0.
